// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg: scancode constants, output key codes, FSM state encoding
// and small classification helpers shared by the PS/2 keyboard decoder.
package ps2_keyboard_pkg;

    // Set-2 scancode prefixes and modifier keys
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Extended (E0-prefixed) arrow scancodes
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LEFT   = 8'h6B;

    // Terminal cursor codes emitted for the arrow keys
    localparam logic [7:0] KEY_UP    = 8'h80;
    localparam logic [7:0] KEY_DOWN  = 8'h81;
    localparam logic [7:0] KEY_RIGHT = 8'h82;
    localparam logic [7:0] KEY_LEFT  = 8'h83;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXT       = 2'd1,
        ST_BREAK     = 2'd2,
        ST_EXT_BREAK = 2'd3
    } ps2_state_e;

    // Keyboard/controller housekeeping bytes that never carry key information
    // and resynchronise the decoder back to IDLE.
    function automatic logic is_ctrl_byte(input logic [7:0] code);
        logic hit;
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    // True for 'A'-'Z' or 'a'-'z'
    function automatic logic is_letter(input logic [7:0] ch);
        return ((ch >= 8'h41) && (ch <= 8'h5A)) || ((ch >= 8'h61) && (ch <= 8'h7A));
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: fixed US-layout set-2 scancode to ASCII ROM.
// Returns 8'h00 for any code without a printable/terminal meaning.
module ps2_keymap
    import ps2_keyboard_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    logic [7:0] lo_s;
    logic [7:0] hi_s;

    // Look up unshifted and shifted characters for the scancode
    always_comb begin
        lo_s = 8'h00;
        hi_s = 8'h00;
        case (code_i)
            8'h1C: begin lo_s = 8'h61; hi_s = 8'h41; end
            8'h32: begin lo_s = 8'h62; hi_s = 8'h42; end
            8'h21: begin lo_s = 8'h63; hi_s = 8'h43; end
            8'h23: begin lo_s = 8'h64; hi_s = 8'h44; end
            8'h24: begin lo_s = 8'h65; hi_s = 8'h45; end
            8'h2B: begin lo_s = 8'h66; hi_s = 8'h46; end
            8'h34: begin lo_s = 8'h67; hi_s = 8'h47; end
            8'h33: begin lo_s = 8'h68; hi_s = 8'h48; end
            8'h43: begin lo_s = 8'h69; hi_s = 8'h49; end
            8'h3B: begin lo_s = 8'h6A; hi_s = 8'h4A; end
            8'h42: begin lo_s = 8'h6B; hi_s = 8'h4B; end
            8'h4B: begin lo_s = 8'h6C; hi_s = 8'h4C; end
            8'h3A: begin lo_s = 8'h6D; hi_s = 8'h4D; end
            8'h31: begin lo_s = 8'h6E; hi_s = 8'h4E; end
            8'h44: begin lo_s = 8'h6F; hi_s = 8'h4F; end
            8'h4D: begin lo_s = 8'h70; hi_s = 8'h50; end
            8'h15: begin lo_s = 8'h71; hi_s = 8'h51; end
            8'h2D: begin lo_s = 8'h72; hi_s = 8'h52; end
            8'h1B: begin lo_s = 8'h73; hi_s = 8'h53; end
            8'h2C: begin lo_s = 8'h74; hi_s = 8'h54; end
            8'h3C: begin lo_s = 8'h75; hi_s = 8'h55; end
            8'h2A: begin lo_s = 8'h76; hi_s = 8'h56; end
            8'h1D: begin lo_s = 8'h77; hi_s = 8'h57; end
            8'h22: begin lo_s = 8'h78; hi_s = 8'h58; end
            8'h35: begin lo_s = 8'h79; hi_s = 8'h59; end
            8'h1A: begin lo_s = 8'h7A; hi_s = 8'h5A; end
            8'h45: begin lo_s = 8'h30; hi_s = 8'h29; end
            8'h16: begin lo_s = 8'h31; hi_s = 8'h21; end
            8'h1E: begin lo_s = 8'h32; hi_s = 8'h40; end
            8'h26: begin lo_s = 8'h33; hi_s = 8'h23; end
            8'h25: begin lo_s = 8'h34; hi_s = 8'h24; end
            8'h2E: begin lo_s = 8'h35; hi_s = 8'h25; end
            8'h36: begin lo_s = 8'h36; hi_s = 8'h5E; end
            8'h3D: begin lo_s = 8'h37; hi_s = 8'h26; end
            8'h3E: begin lo_s = 8'h38; hi_s = 8'h2A; end
            8'h46: begin lo_s = 8'h39; hi_s = 8'h28; end
            8'h0E: begin lo_s = 8'h60; hi_s = 8'h7E; end
            8'h4E: begin lo_s = 8'h2D; hi_s = 8'h5F; end
            8'h55: begin lo_s = 8'h3D; hi_s = 8'h2B; end
            8'h54: begin lo_s = 8'h5B; hi_s = 8'h7B; end
            8'h5B: begin lo_s = 8'h5D; hi_s = 8'h7D; end
            8'h5D: begin lo_s = 8'h5C; hi_s = 8'h7C; end
            8'h4C: begin lo_s = 8'h3B; hi_s = 8'h3A; end
            8'h52: begin lo_s = 8'h27; hi_s = 8'h22; end
            8'h41: begin lo_s = 8'h2C; hi_s = 8'h3C; end
            8'h49: begin lo_s = 8'h2E; hi_s = 8'h3E; end
            8'h4A: begin lo_s = 8'h2F; hi_s = 8'h3F; end
            // Fixed terminal codes ignore shift
            8'h5A: begin lo_s = 8'h0D; hi_s = 8'h0D; end
            8'h66: begin lo_s = 8'h08; hi_s = 8'h08; end
            8'h76: begin lo_s = 8'h1B; hi_s = 8'h1B; end
            8'h0D: begin lo_s = 8'h09; hi_s = 8'h09; end
            8'h29: begin lo_s = 8'h20; hi_s = 8'h20; end
            default: begin lo_s = 8'h00; hi_s = 8'h00; end
        endcase
    end

    assign ascii_o = shift_i ? hi_s : lo_s;

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: decodes PS/2 set-2 scancode bytes into ASCII / cursor key
// codes. Tracks make/break and E0 prefixes, shift and ctrl state, and holds
// one output key in a registered slot that back-pressures the byte input.
// Optional feature: define PS2_CAPS_LOCK_EN to add a caps-lock toggle.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       key_valid_o,
    output logic [7:0] key_data_o,
    input  logic       key_ready_i
);

    ps2_state_e state_q, state_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       ctrl_l_q,  ctrl_l_d;
    logic       ctrl_r_q,  ctrl_r_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_data_q,  key_data_d;
    logic       rx_ready_q;
`ifdef PS2_CAPS_LOCK_EN
    logic       caps_q,      caps_d;
    logic       caps_held_q, caps_held_d;
`endif

    logic       accept_s;
    logic       shift_s;
    logic       ctrl_s;
    logic [7:0] map_ascii_s;
    logic [7:0] ascii_s;
    logic [7:0] emit_s;

    assign accept_s = rx_valid_i && rx_ready_q;
    assign shift_s  = shift_l_q | shift_r_q;
    assign ctrl_s   = ctrl_l_q | ctrl_r_q;

    ps2_keymap u_keymap (
        .code_i  (rx_data_i),
        .shift_i (shift_s),
        .ascii_o (map_ascii_s)
    );

    // Apply caps lock to letters, then fold ctrl into the control range
    always_comb begin
        ascii_s = map_ascii_s;
`ifdef PS2_CAPS_LOCK_EN
        if (caps_q && is_letter(map_ascii_s)) begin
            ascii_s = map_ascii_s ^ 8'h20;
        end else begin
            ascii_s = map_ascii_s;
        end
`endif
        if (ctrl_s && (ascii_s[7:6] == 2'b01)) begin
            emit_s = ascii_s & 8'h1F;
        end else begin
            emit_s = ascii_s;
        end
    end

    // Next-state logic for the decoder FSM, modifiers and output slot
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        ctrl_l_d    = ctrl_l_q;
        ctrl_r_d    = ctrl_r_q;
        key_data_d  = key_data_q;
`ifdef PS2_CAPS_LOCK_EN
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
`endif
        if (key_valid_q && key_ready_i) begin
            key_valid_d = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end

        // A byte is only accepted while the slot is empty, so a new key
        // never collides with a pending one.
        if (accept_s) begin
            if (is_ctrl_byte(rx_data_i)) begin
                state_d = ST_IDLE;
            end else if (rx_data_i == SC_PAUSE) begin
                state_d = state_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data_i == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (rx_data_i == SC_BREAK) begin
                            state_d = ST_BREAK;
                        end else if (rx_data_i == SC_LSHIFT) begin
                            shift_l_d = 1'b1;
                        end else if (rx_data_i == SC_RSHIFT) begin
                            shift_r_d = 1'b1;
                        end else if (rx_data_i == SC_CTRL) begin
                            ctrl_l_d = 1'b1;
                        end else if (rx_data_i == SC_CAPS) begin
`ifdef PS2_CAPS_LOCK_EN
                            // Typematic repeats of caps must not re-toggle
                            if (!caps_held_q) begin
                                caps_d = ~caps_q;
                            end else begin
                                caps_d = caps_q;
                            end
                            caps_held_d = 1'b1;
`else
                            state_d = ST_IDLE;
`endif
                        end else if (map_ascii_s != 8'h00) begin
                            key_valid_d = 1'b1;
                            key_data_d  = emit_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_EXT: begin
                        state_d = ST_IDLE;
                        case (rx_data_i)
                            SC_BREAK: state_d = ST_EXT_BREAK;
                            SC_CTRL:  ctrl_r_d = 1'b1;
                            SC_UP:    begin key_valid_d = 1'b1; key_data_d = KEY_UP;    end
                            SC_DOWN:  begin key_valid_d = 1'b1; key_data_d = KEY_DOWN;  end
                            SC_RIGHT: begin key_valid_d = 1'b1; key_data_d = KEY_RIGHT; end
                            SC_LEFT:  begin key_valid_d = 1'b1; key_data_d = KEY_LEFT;  end
                            default:  state_d = ST_IDLE;
                        endcase
                    end
                    ST_BREAK: begin
                        state_d = ST_IDLE;
                        case (rx_data_i)
                            SC_LSHIFT: shift_l_d = 1'b0;
                            SC_RSHIFT: shift_r_d = 1'b0;
                            SC_CTRL:   ctrl_l_d  = 1'b0;
`ifdef PS2_CAPS_LOCK_EN
                            SC_CAPS:   caps_held_d = 1'b0;
`endif
                            default:   state_d = ST_IDLE;
                        endcase
                    end
                    ST_EXT_BREAK: begin
                        state_d = ST_IDLE;
                        if (rx_data_i == SC_CTRL) begin
                            ctrl_r_d = 1'b0;
                        end else begin
                            ctrl_r_d = ctrl_r_q;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Register FSM state, modifiers and the output slot
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            ctrl_l_q    <= 1'b0;
            ctrl_r_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_data_q  <= 8'h00;
            rx_ready_q  <= 1'b1;
`ifdef PS2_CAPS_LOCK_EN
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            ctrl_l_q    <= ctrl_l_d;
            ctrl_r_q    <= ctrl_r_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
            // Ready is the registered complement of the slot occupancy
            rx_ready_q  <= ~key_valid_d;
`ifdef PS2_CAPS_LOCK_EN
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
`endif
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign key_valid_o = key_valid_q;
    assign key_data_o  = key_data_q;

endmodule
